// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO: width math and parameter legality.
package fifo_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit params_ok(input int unsigned depth, input int unsigned af,
                                   input int unsigned ae);
    return (depth >= 2) && (depth <= 1024) && (af >= 1) && (af <= depth) && (ae < depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH simple dual-port register array with a registered, enabled read port.
module fifo_mem #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage is never reset; a read of the address being written returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: pointers with explicit wrap, occupancy, flags and error pulses.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned DEPTH    = 16,
  parameter  int unsigned AF_LEVEL = 12,
  parameter  int unsigned AE_LEVEL = 4,
  localparam int unsigned ADDR_W   = clog2(DEPTH),
  localparam int unsigned CNT_W    = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd,
  output logic [WIDTH-1:0] data_out,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  if (!params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_err
    $error("sync_fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rd_valid_q, overflow_q, underflow_q;
  logic              rd_acc_c, wr_acc_c;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  // A write at full only goes in when a read frees the slot in the same cycle.
  always_comb begin
    rd_acc_c = rd & ~empty;
    wr_acc_c = wr & (~full | rd_acc_c);
    wr_ptr_d = wr_acc_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_acc_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    unique case ({wr_acc_c, rd_acc_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_acc_c;
      overflow_q  <= wr & ~wr_acc_c;
      underflow_q <= rd & ~rd_acc_c;
    end
  end

  fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (wr_acc_c & ~reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .re_i    (rd_acc_c),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_out)
  );

  assign count        = count_q;
  assign rd_valid     = rd_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: table vectors plus scoreboard-driven sequences on a 16-deep and a 5-deep FIFO.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr16, rd16, wr5, rd5;
  logic [7:0] din16, din5;
  logic [7:0] dout16, dout5;
  logic       vld16, full16, empty16, af16, ae16, ovf16, unf16;
  logic       vld5, full5, empty5, af5, ae5, ovf5, unf5;
  logic [4:0] cnt16;
  logic [2:0] cnt5;

  int errors = 0;
  int checks = 0;

  logic [7:0] q16[$];
  logic [7:0] q5[$];
  logic [7:0] last16, last5;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4)) u_dut16 (
    .clk(clk), .reset(reset), .wr(wr16), .data_in(din16), .rd(rd16),
    .data_out(dout16), .rd_valid(vld16), .full(full16), .empty(empty16),
    .almost_full(af16), .almost_empty(ae16), .count(cnt16),
    .overflow(ovf16), .underflow(unf16)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut5 (
    .clk(clk), .reset(reset), .wr(wr5), .data_in(din5), .rd(rd5),
    .data_out(dout5), .rd_valid(vld5), .full(full5), .empty(empty5),
    .almost_full(af5), .almost_empty(ae5), .count(cnt5),
    .overflow(ovf5), .underflow(unf5)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // One clock on the selected FIFO (0 = 16-deep, 1 = 5-deep) with full output check against the model.
  task automatic cyc(input int sel, input bit w, input logic [7:0] d, input bit r);
    int depth, af, ae, sz;
    bit ra, wa;
    depth = (sel != 0) ? 5 : 16;
    af    = (sel != 0) ? 4 : 12;
    ae    = (sel != 0) ? 1 : 4;
    sz    = (sel != 0) ? q5.size() : q16.size();
    ra    = r && (sz > 0);
    wa    = w && ((sz < depth) || ra);
    if (sel != 0) begin
      if (ra) last5 = q5.pop_front();
      if (wa) q5.push_back(d);
      wr5 = w; din5 = d; rd5 = r;
    end else begin
      if (ra) last16 = q16.pop_front();
      if (wa) q16.push_back(d);
      wr16 = w; din16 = d; rd16 = r;
    end
    @(posedge clk);
    #1;
    wr16 = 1'b0; rd16 = 1'b0; wr5 = 1'b0; rd5 = 1'b0;
    if (sel != 0) begin
      sz = q5.size();
      chk("count5", int'(cnt5), sz);
      chk("full5", int'(full5), int'(sz == depth));
      chk("empty5", int'(empty5), int'(sz == 0));
      chk("af5", int'(af5), int'(sz >= af));
      chk("ae5", int'(ae5), int'(sz <= ae));
      chk("rd_valid5", int'(vld5), int'(ra));
      chk("overflow5", int'(ovf5), int'(w && !wa));
      chk("underflow5", int'(unf5), int'(r && !ra));
      chk("data_out5", int'(dout5), int'(last5));
    end else begin
      sz = q16.size();
      chk("count16", int'(cnt16), sz);
      chk("full16", int'(full16), int'(sz == depth));
      chk("empty16", int'(empty16), int'(sz == 0));
      chk("af16", int'(af16), int'(sz >= af));
      chk("ae16", int'(ae16), int'(sz <= ae));
      chk("rd_valid16", int'(vld16), int'(ra));
      chk("overflow16", int'(ovf16), int'(w && !wa));
      chk("underflow16", int'(unf16), int'(r && !ra));
      chk("data_out16", int'(dout16), int'(last16));
    end
  endtask

  // Hold reset for n cycles with optional wr/rd on the 16-deep FIFO, then check reset values.
  task automatic do_reset(input int n, input bit w, input bit r);
    reset = 1'b1;
    wr16 = w; rd16 = r; din16 = 8'hEE;
    repeat (n) @(posedge clk);
    #1;
    q16.delete(); q5.delete();
    last16 = 8'h00; last5 = 8'h00;
    chk("rst_count16", int'(cnt16), 0);
    chk("rst_empty16", int'(empty16), 1);
    chk("rst_ae16", int'(ae16), 1);
    chk("rst_full16", int'(full16), 0);
    chk("rst_af16", int'(af16), 0);
    chk("rst_dout16", int'(dout16), 0);
    chk("rst_valid16", int'(vld16), 0);
    chk("rst_ovf16", int'(ovf16), 0);
    chk("rst_unf16", int'(unf16), 0);
    chk("rst_count5", int'(cnt5), 0);
    chk("rst_empty5", int'(empty5), 1);
    reset = 1'b0;
    wr16 = 1'b0; rd16 = 1'b0;
  endtask

  typedef struct {
    bit         w;
    logic [7:0] d;
    bit         r;
    int         cnt;
    logic [7:0] dout;
    bit         vld;
    bit         unf;
  } vec_t;

  vec_t tbl[6];

  initial begin
    reset = 1'b1;
    wr16 = 1'b0; rd16 = 1'b0; din16 = 8'h00;
    wr5 = 1'b0; rd5 = 1'b0; din5 = 8'h00;
    last16 = 8'h00; last5 = 8'h00;

    // Reset and idle
    do_reset(2, 1'b0, 1'b0);
    cyc(0, 1'b0, 8'h00, 1'b0);
    cyc(0, 1'b0, 8'h00, 1'b0);

    // Hand-computed short sequence
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 2, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h33, 1'b1, 2, 8'h11, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1, 8'h22, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 0, 8'h33, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 0, 8'h33, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      cyc(0, tbl[i].w, tbl[i].d, tbl[i].r);
      chk("tbl_count", int'(cnt16), tbl[i].cnt);
      chk("tbl_dout", int'(dout16), int'(tbl[i].dout));
      chk("tbl_valid", int'(vld16), int'(tbl[i].vld));
      chk("tbl_underflow", int'(unf16), int'(tbl[i].unf));
    end

    // Fill to full, then one rejected write
    for (int i = 1; i <= 16; i++) cyc(0, 1'b1, 8'(i), 1'b0);
    cyc(0, 1'b1, 8'hFF, 1'b0);
    chk("fill_overflow", int'(ovf16), 1);
    chk("fill_count", int'(cnt16), 16);
    cyc(0, 1'b0, 8'h00, 1'b0);
    chk("overflow_pulse", int'(ovf16), 0);

    // Drain in order, then one rejected read
    for (int i = 0; i < 17; i++) cyc(0, 1'b0, 8'h00, 1'b1);
    chk("drain_underflow", int'(unf16), 1);
    chk("drain_hold", int'(dout16), 16);

    // Simultaneous wr+rd at full: old word out, new word lands behind 15 others
    for (int i = 1; i <= 16; i++) cyc(0, 1'b1, 8'(8'h40 + i), 1'b0);
    cyc(0, 1'b1, 8'h77, 1'b1);
    chk("full_both_count", int'(cnt16), 16);
    chk("full_both_dout", int'(dout16), 8'h41);
    chk("full_both_ovf", int'(ovf16), 0);
    for (int i = 0; i < 16; i++) cyc(0, 1'b0, 8'h00, 1'b1);
    chk("full_both_new_last", int'(dout16), 8'h77);

    // Simultaneous wr+rd at empty: no fall-through
    cyc(0, 1'b1, 8'h55, 1'b1);
    chk("empty_both_unf", int'(unf16), 1);
    chk("empty_both_count", int'(cnt16), 1);
    cyc(0, 1'b0, 8'h00, 1'b1);
    chk("empty_both_read", int'(dout16), 8'h55);

    // Wrap-around on the 5-deep build
    for (int i = 0; i < 12; i++) cyc(1, 1'b1, 8'(8'hA0 + i), i >= 2);
    cyc(1, 1'b0, 8'h00, 1'b1);
    cyc(1, 1'b0, 8'h00, 1'b1);
    chk("wrap_last", int'(dout5), 8'hAB);
    chk("wrap_empty", int'(empty5), 1);

    // Mid-operation reset with concurrent wr and rd
    for (int i = 0; i < 7; i++) cyc(0, 1'b1, 8'(8'h90 + i), 1'b0);
    do_reset(1, 1'b1, 1'b1);
    cyc(0, 1'b1, 8'h3C, 1'b0);
    cyc(0, 1'b0, 8'h00, 1'b1);
    chk("post_reset_read", int'(dout16), 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
